apb_fifo_completer: RTL and testbench

- APB completer (slave) sitting directly downstream of the team's APB requester. It is selected by one bit of the requester's one-hot PSEL bus, e.g. the P1 slot at 0x1000_1xxx.
- It bridges APB register accesses to two stream FIFOs:
  - TX FIFO: APB writes, drained by a valid/ready consumer.
  - RX FIFO: filled by a valid/ready producer, read over APB.
- Adds a programmable wait-state count on PREADY so the bench can exercise the requester's ACCESS-hold path.

---
 rtl/apb_fifo_completer.sv | 223 ++++++++++++++++++++++
 tb/tb_apb_fifo_completer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_completer.sv
// apb_fifo_completer
//   APB completer bridging register accesses to two stream FIFOs.
//   TX FIFO is filled by APB writes to TXDATA and drained by a valid/ready
//   consumer; RX FIFO is filled by a valid/ready producer and drained by APB
//   reads of RXDATA. A programmable wait count (CTRL.WAIT) stretches PREADY.
// Ports:
//   PCLK, PRESET (async, active-high)
//   PSEL, PENABLE, PWRITE, PADDR[31:0], PWDATA[DW-1:0] : APB request
//   PRDATA[DW-1:0], PREADY                              : APB response
//   tx_valid, tx_data[DW-1:0], tx_ready                 : TX stream out
//   rx_valid, rx_data[DW-1:0], rx_ready                 : RX stream in
module apb_fifo_completer #(
    parameter int DEPTH = 8,
    parameter int DW    = 32
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [31:0]   PADDR,
    input  logic [DW-1:0] PWDATA,
    output logic [DW-1:0] PRDATA,
    output logic          PREADY,
    output logic          tx_valid,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ready,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    output logic          rx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [3:0]     cnt_r;
    logic           cnt_load_s, cnt_dec_s;

    logic           ctrl_tx_en_r;
    logic [3:0]     ctrl_wait_r;
    logic           ovf_r, unf_r;

    logic [DW-1:0]  tx_mem_r [DEPTH];
    logic [DW-1:0]  rx_mem_r [DEPTH];
    logic [AW-1:0]  tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
    logic [CW-1:0]  tx_count_r, rx_count_r;

    logic           setup_s, commit_s, wr_s, rd_s, mapped_s;
    logic [1:0]     reg_sel_s;
    logic           tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic           tx_push_req_s, tx_push_s, tx_pop_s;
    logic           rx_pop_req_s, rx_pop_s, rx_push_s;
    logic           ovf_set_s, unf_set_s, ovf_clr_s, unf_clr_s, ctrl_wr_s;
    logic [31:0]    status_s;
    logic [DW-1:0]  rd_mux_s;
    logic           unused_addr_s;

    assign unused_addr_s = ^{PADDR[31:12], PADDR[1:0]};

    assign setup_s   = PSEL & ~PENABLE;
    assign PREADY    = (state_r == S_DONE) & PSEL & PENABLE;
    assign commit_s  = PREADY;
    assign wr_s      = commit_s & PWRITE;
    assign rd_s      = commit_s & ~PWRITE;
    assign mapped_s  = (PADDR[11:4] == 8'd0);
    assign reg_sel_s = PADDR[3:2];

    assign tx_full_s  = (tx_count_r == FULL_CNT);
    assign tx_empty_s = (tx_count_r == {CW{1'b0}});
    assign rx_full_s  = (rx_count_r == FULL_CNT);
    assign rx_empty_s = (rx_count_r == {CW{1'b0}});

    // Full/empty checks use registered counts, so a same-cycle pop never
    // rescues a push into a full FIFO (and vice versa for empty reads).
    assign tx_push_req_s = wr_s & mapped_s & (reg_sel_s == 2'd0);
    assign tx_push_s     = tx_push_req_s & ~tx_full_s;
    assign ovf_set_s     = tx_push_req_s & tx_full_s;
    assign rx_pop_req_s  = rd_s & mapped_s & (reg_sel_s == 2'd1);
    assign rx_pop_s      = rx_pop_req_s & ~rx_empty_s;
    assign unf_set_s     = rx_pop_req_s & rx_empty_s;
    assign ovf_clr_s     = wr_s & mapped_s & (reg_sel_s == 2'd2) & PWDATA[4];
    assign unf_clr_s     = wr_s & mapped_s & (reg_sel_s == 2'd2) & PWDATA[5];
    assign ctrl_wr_s     = wr_s & mapped_s & (reg_sel_s == 2'd3);

    assign tx_valid  = ctrl_tx_en_r & ~tx_empty_s;
    assign tx_data   = tx_mem_r[tx_rd_ptr_r];
    assign tx_pop_s  = tx_valid & tx_ready;
    assign rx_ready  = ~rx_full_s;
    assign rx_push_s = rx_valid & ~rx_full_s;

    // Wait-state FSM: next state and counter controls.
    always_comb begin
        state_nxt_s = state_r;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                // A setup phase right after a commit starts the next transfer.
                if (setup_s) begin
                    cnt_load_s  = 1'b1;
                    state_nxt_s = (ctrl_wait_r == 4'd0) ? S_DONE : S_WAIT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_nxt_s = S_IDLE;
                end else if (PENABLE) begin
                    cnt_dec_s   = 1'b1;
                    state_nxt_s = (cnt_r <= 4'd1) ? S_DONE : S_WAIT;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Wait-state FSM: state and wait counter registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= S_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (cnt_load_s) begin
                cnt_r <= ctrl_wait_r;
            end else if (cnt_dec_s) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Control and sticky error flags; a set beats a clear in the same cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_tx_en_r <= 1'b0;
            ctrl_wait_r  <= 4'd0;
            ovf_r        <= 1'b0;
            unf_r        <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                ctrl_tx_en_r <= PWDATA[0];
                ctrl_wait_r  <= PWDATA[11:8];
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end
            if (unf_set_s) begin
                unf_r <= 1'b1;
            end else if (unf_clr_s) begin
                unf_r <= 1'b0;
            end
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_wr_ptr_r <= {AW{1'b0}};
            tx_rd_ptr_r <= {AW{1'b0}};
            tx_count_r  <= {CW{1'b0}};
            rx_wr_ptr_r <= {AW{1'b0}};
            rx_rd_ptr_r <= {AW{1'b0}};
            rx_count_r  <= {CW{1'b0}};
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + AW'(1'b1);
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + AW'(1'b1);
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + AW'(1'b1);
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + AW'(1'b1);
            tx_count_r <= tx_count_r + CW'(tx_push_s) - CW'(tx_pop_s);
            rx_count_r <= rx_count_r + CW'(rx_push_s) - CW'(rx_pop_s);
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge PCLK) begin
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= PWDATA;
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_data;
    end

    // Read-data mux; only presented on the commit cycle of a read.
    always_comb begin
        status_s        = 32'd0;
        status_s[0]     = tx_full_s;
        status_s[1]     = tx_empty_s;
        status_s[2]     = rx_full_s;
        status_s[3]     = rx_empty_s;
        status_s[4]     = ovf_r;
        status_s[5]     = unf_r;
        status_s[15:8]  = 8'(tx_count_r);
        status_s[23:16] = 8'(rx_count_r);
        rd_mux_s        = {DW{1'b0}};
        if (mapped_s) begin
            case (reg_sel_s)
                2'd0:    rd_mux_s = {DW{1'b0}};
                2'd1:    rd_mux_s = rx_empty_s ? {DW{1'b0}} : rx_mem_r[rx_rd_ptr_r];
                2'd2:    rd_mux_s = DW'(status_s);
                2'd3:    rd_mux_s = DW'({20'd0, ctrl_wait_r, 7'd0, ctrl_tx_en_r});
                default: rd_mux_s = {DW{1'b0}};
            endcase
        end else begin
            rd_mux_s = {DW{1'b0}};
        end
        if (rd_s) begin
            PRDATA = rd_mux_s;
        end else begin
            PRDATA = {DW{1'b0}};
        end
    end
endmodule

// File: tb/tb_apb_fifo_completer.sv
module tb_apb_fifo_completer;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic [31:0] tx_data, rx_data;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] rdv;
    int          wt;
    logic [31:0] txq[$];

    apb_fifo_completer #(.DEPTH(8), .DW(32)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One APB transfer; called and returns just after a rising edge.
    // pop drives tx_ready high only across the commit edge.
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic pop, output logic [31:0] rd, output int waits);
        rd = 32'd0;
        waits = 0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        while (PREADY !== 1'b1 && waits < 64) begin
            @(negedge PCLK);
            waits++;
        end
        chk("pready", {31'd0, PREADY}, 32'd1);
        rd = PRDATA;
        tx_ready = pop;
        @(posedge PCLK); #1;
        tx_ready = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd0; PWDATA = 32'd0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'd0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_pready", {31'd0, PREADY}, 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_txvalid", {31'd0, tx_valid}, 32'd0);
        chk("rst_rxready", {31'd0, rx_ready}, 32'd1);
        PRESET = 1'b0;
        @(posedge PCLK); #1;

        // zero-wait STATUS read
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("status0", rdv, 32'h0000_000A);
        chk("waits0", wt, 32'd0);

        // CTRL wait states and readback
        apb(1'b1, 32'h100C, 32'h0000_0301, 1'b0, rdv, wt);
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("status_w3", rdv, 32'h0000_000A);
        chk("waits3", wt, 32'd3);
        apb(1'b0, 32'h100C, 32'd0, 1'b0, rdv, wt);
        chk("ctrl_rd", rdv, 32'h0000_0301);

        // CTRL reserved bits read as 0; max wait count
        apb(1'b1, 32'h100C, 32'hFFFF_FFFF, 1'b0, rdv, wt);
        apb(1'b0, 32'h100C, 32'd0, 1'b0, rdv, wt);
        chk("ctrl_mask", rdv, 32'h0000_0F01);
        chk("waits15", wt, 32'd15);
        apb(1'b1, 32'h100C, 32'h0000_0301, 1'b0, rdv, wt);

        // unmapped: write ignored, read 0
        apb(1'b1, 32'h1010, 32'h1234_5678, 1'b0, rdv, wt);
        apb(1'b0, 32'h1010, 32'd0, 1'b0, rdv, wt);
        chk("unmapped_rd", rdv, 32'd0);
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("unmapped_nofx", rdv, 32'h0000_000A);

        // fill TX past full
        for (int i = 0; i < 9; i++) apb(1'b1, 32'h1000, 32'h100 + i, 1'b0, rdv, wt);
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("status_full", rdv, 32'h0000_0819);
        apb(1'b0, 32'h1000, 32'd0, 1'b0, rdv, wt);
        chk("txdata_rd", rdv, 32'd0);

        // drain TX
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            chk("drain_valid", {31'd0, tx_valid}, 32'd1);
            chk("drain_data", tx_data, 32'h100 + i);
        end
        @(negedge PCLK);
        chk("drain_end", {31'd0, tx_valid}, 32'd0);
        @(posedge PCLK); #1;
        tx_ready = 1'b0;
        apb(1'b1, 32'h1008, 32'h0000_0010, 1'b0, rdv, wt);
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("ovf_clr", rdv, 32'h0000_000A);

        // RX producer and reads, underflow
        rx_valid = 1'b1; rx_data = 32'hA5A5_0001;
        @(posedge PCLK); #1;
        rx_data = 32'hA5A5_0002;
        @(posedge PCLK); #1;
        rx_valid = 1'b0;
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("status_rx2", rdv, 32'h0002_0002);
        apb(1'b0, 32'h1004, 32'd0, 1'b0, rdv, wt);
        chk("rx_rd1", rdv, 32'hA5A5_0001);
        apb(1'b0, 32'h1004, 32'd0, 1'b0, rdv, wt);
        chk("rx_rd2", rdv, 32'hA5A5_0002);
        apb(1'b0, 32'h1004, 32'd0, 1'b0, rdv, wt);
        chk("rx_rd_empty", rdv, 32'd0);
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("status_unf", rdv, 32'h0000_002A);
        apb(1'b1, 32'h1008, 32'h0000_0020, 1'b0, rdv, wt);
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("unf_clr", rdv, 32'h0000_000A);

        // simultaneous push/pop with pointer wrap
        for (int i = 0; i < 3; i++) begin
            apb(1'b1, 32'h1000, 32'h200 + i, 1'b0, rdv, wt);
            txq.push_back(32'h200 + i);
        end
        for (int i = 0; i < 20; i++) begin
            chk("pp_head", tx_data, txq[0]);
            apb(1'b1, 32'h1000, 32'h300 + i, 1'b1, rdv, wt);
            void'(txq.pop_front());
            txq.push_back(32'h300 + i);
        end
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("pp_status", rdv, 32'h0000_0308);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk("pp_drain", tx_data, txq[i]);
        end
        @(negedge PCLK);
        chk("pp_drain_end", {31'd0, tx_valid}, 32'd0);
        @(posedge PCLK); #1;
        tx_ready = 1'b0;

        // reset during wait states of a TXDATA write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h1000; PWDATA = 32'hDEAD_BEEF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("rst_wait_pready", {31'd0, PREADY}, 32'd0);
        PRESET = 1'b1;
        #1;
        chk("rst_mid_pready", {31'd0, PREADY}, 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("rst_mid_status", rdv, 32'h0000_000A);
        chk("rst_mid_waits", wt, 32'd0);
        apb(1'b0, 32'h100C, 32'd0, 1'b0, rdv, wt);
        chk("rst_mid_ctrl", rdv, 32'd0);
        apb(1'b1, 32'h1000, 32'h0000_0055, 1'b0, rdv, wt);
        apb(1'b0, 32'h1008, 32'd0, 1'b0, rdv, wt);
        chk("post_rst_push", rdv, 32'h0000_0108);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
